// File: rtl/id_token_collector_if.sv
// Token stream interface between id_token_collector and its consumer.
//   tok_valid : head of token FIFO is valid
//   tok_ready : consumer accepts the head when tok_valid & tok_ready
//   tok_len   : length of the head token
//   tok_first : first character of the head token (0 when not stored)
// master: producer side (id_token_collector); slave: consumer side.
interface id_token_collector_if #(
  parameter int unsigned LEN_W = 6
) ();
  logic             tok_valid;
  logic             tok_ready;
  logic [LEN_W-1:0] tok_len;
  logic [7:0]       tok_first;

  modport master (
    output tok_valid,
    output tok_len,
    output tok_first,
    input  tok_ready
  );

  modport slave (
    input  tok_valid,
    input  tok_len,
    input  tok_first,
    output tok_ready
  );
endinterface

// File: rtl/id_token_collector.sv
// id_token_collector: measures identifier runs on an ASCII stream and queues
// the length of every run that the upstream identifier FSM flags as valid.
//
// Ports:
//   clk      : clock, all state on posedge
//   rst_n    : synchronous active-low reset
//   char     : current ASCII character (same cycle as the FSM input)
//   id_match : FSM flag, high when the chars up to the previous cycle end a
//              valid identifier
//   tok      : token stream (valid/ready, length, first char), master side
//   id_count : identifiers pushed (including dropped) since reset, wraps
//   overflow : sticky, a token was dropped because the FIFO was full
//   drop_cnt : dropped tokens, saturates at 255
//
// Optional feature macro: TOKEN_FIRST_CHAR_EN. When defined, each FIFO entry
// also stores the first char of the run and drives it on tok_first; when
// undefined tok_first is tied to 8'h00.
module id_token_collector #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned LEN_W = 6,
  parameter int unsigned CNT_W = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  char,
  input  logic                        id_match,
  id_token_collector_if.master        tok,
  output logic [CNT_W-1:0]            id_count,
  output logic                        overflow,
  output logic [7:0]                  drop_cnt
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  typedef enum logic {StIdle, StRun} run_state_e;

  run_state_e       state_q, state_d;
  logic [LEN_W-1:0] run_len_q, run_len_d;

  logic is_letter, is_digit, is_delim;

  assign is_letter = ((char >= 8'd65) && (char <= 8'd90)) ||
                     ((char >= 8'd97) && (char <= 8'd122));
  assign is_digit  = (char >= 8'd48) && (char <= 8'd57);
  assign is_delim  = !is_letter && !is_digit;

`ifdef TOKEN_FIRST_CHAR_EN
  logic [7:0] first_q, first_d;
  logic [7:0] first_mem [DEPTH];
`endif

  // Run tracker
  always_comb begin
    state_d   = state_q;
    run_len_d = run_len_q;
`ifdef TOKEN_FIRST_CHAR_EN
    first_d   = first_q;
`endif
    case (state_q)
      StIdle: begin
        if (is_letter) begin
          state_d   = StRun;
          run_len_d = LEN_W'(1);
`ifdef TOKEN_FIRST_CHAR_EN
          first_d   = char;
`endif
        end
      end
      StRun: begin
        if (is_delim) begin
          state_d = StIdle;
        end else if (run_len_q != '1) begin
          run_len_d = run_len_q + LEN_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      run_len_q <= '0;
`ifdef TOKEN_FIRST_CHAR_EN
      first_q   <= '0;
`endif
    end else begin
      state_q   <= state_d;
      run_len_q <= run_len_d;
`ifdef TOKEN_FIRST_CHAR_EN
      first_q   <= first_d;
`endif
    end
  end

  // Token FIFO; pointers carry one extra bit to tell full from empty.
  logic [PtrW:0]    wr_ptr_q, rd_ptr_q;
  logic [LEN_W-1:0] len_mem [DEPTH];
  logic             empty, full, push_req, pop, push_acc, drop;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                    (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
  assign push_req = is_delim && id_match && (state_q == StRun);
  assign pop      = !empty && tok.tok_ready;
  // A pop in the same cycle frees a slot, so a push into a full FIFO survives.
  assign push_acc = push_req && (!full || pop);
  assign drop     = push_req && full && !pop;

  always_ff @(posedge clk) begin
    if (push_acc) begin
      len_mem[wr_ptr_q[PtrW-1:0]]   <= run_len_q;
`ifdef TOKEN_FIRST_CHAR_EN
      first_mem[wr_ptr_q[PtrW-1:0]] <= first_q;
`endif
    end
  end

  logic [CNT_W-1:0] id_count_q;
  logic             overflow_q;
  logic [7:0]       drop_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      id_count_q <= '0;
      overflow_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      if (push_acc) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)      rd_ptr_q <= rd_ptr_q + 1'b1;
      if (push_req) id_count_q <= id_count_q + 1'b1;
      if (drop) begin
        overflow_q <= 1'b1;
        if (drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
      end
    end
  end

  // Head outputs are forced to zero while empty so reset shows clean values
  // without clearing the storage array.
  assign tok.tok_valid = !empty;
  assign tok.tok_len   = empty ? '0 : len_mem[rd_ptr_q[PtrW-1:0]];
`ifdef TOKEN_FIRST_CHAR_EN
  assign tok.tok_first = empty ? 8'h00 : first_mem[rd_ptr_q[PtrW-1:0]];
`else
  assign tok.tok_first = 8'h00;
`endif

  assign id_count = id_count_q;
  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_id_token_collector.sv
module tb_id_token_collector;

  localparam int DEPTH = 4;
  localparam int LEN_W = 6;
  localparam int CNT_W = 16;
  localparam int LEN_MAX = (1 << LEN_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       char;
  logic             id_match;
  logic [CNT_W-1:0] id_count;
  logic             overflow;
  logic [7:0]       drop_cnt;

  id_token_collector_if #(.LEN_W(LEN_W)) tok ();

  id_token_collector #(
    .DEPTH(DEPTH),
    .LEN_W(LEN_W),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .char     (char),
    .id_match (id_match),
    .tok      (tok),
    .id_count (id_count),
    .overflow (overflow),
    .drop_cnt (drop_cnt)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model: current word as text-level facts, token queue, counters.
  bit         word_act;
  int         word_len;
  logic [7:0] word_first;
  int         q_len[$];
  logic [7:0] q_first[$];
  int         m_count;
  bit         m_ovf;
  int         m_drop;
  logic [7:0] prev_c;

  function automatic bit is_letter(input logic [7:0] c);
    return (c >= "A" && c <= "Z") || (c >= "a" && c <= "z");
  endfunction

  function automatic bit is_digit(input logic [7:0] c);
    return c >= "0" && c <= "9";
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    word_act = 0;
    word_len = 0;
    word_first = 8'h00;
    q_len.delete();
    q_first.delete();
    m_count = 0;
    m_ovf = 0;
    m_drop = 0;
    prev_c = " ";
  endtask

  task automatic model_edge(input logic [7:0] c, input bit m, input bit r);
    bit         pop;
    bit         push;
    int         plen;
    logic [7:0] pf;
    pop  = (q_len.size() > 0) && r;
    push = !is_letter(c) && !is_digit(c) && m && word_act;
    plen = (word_len > LEN_MAX) ? LEN_MAX : word_len;
    pf   = word_first;
    if (!is_letter(c) && !is_digit(c)) begin
      word_act = 0;
    end else if (word_act) begin
      word_len++;
    end else if (is_letter(c)) begin
      word_act = 1;
      word_len = 1;
      word_first = c;
    end
    if (pop) begin
      void'(q_len.pop_front());
      void'(q_first.pop_front());
    end
    if (push) begin
      m_count = (m_count + 1) % (1 << CNT_W);
      if (q_len.size() < DEPTH) begin
        q_len.push_back(plen);
        q_first.push_back(pf);
      end else begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end
    end
  endtask

  task automatic check_outputs(input string tag);
    bit v;
    v = q_len.size() > 0;
    chk({tag, "_valid"}, 32'(tok.tok_valid), 32'(v));
    if (v) begin
      chk({tag, "_len"}, 32'(tok.tok_len), 32'(q_len[0]));
`ifdef TOKEN_FIRST_CHAR_EN
      chk({tag, "_first"}, 32'(tok.tok_first), 32'(q_first[0]));
`else
      chk({tag, "_first"}, 32'(tok.tok_first), 32'h0);
`endif
    end
    chk({tag, "_count"}, 32'(id_count), 32'(m_count));
    chk({tag, "_ovf"}, 32'(overflow), 32'(m_ovf));
    chk({tag, "_drop"}, 32'(drop_cnt), 32'(m_drop));
  endtask

  // Upstream FSM stand-in: flags a word that began with a letter and whose
  // last character was a digit.
  function automatic bit gen_match();
    return word_act && is_digit(prev_c);
  endfunction

  // Called at negedge: drive inputs, check state, advance model, next negedge.
  task automatic step(input logic [7:0] c, input bit m, input bit r);
    char = c;
    id_match = m;
    tok.tok_ready = r;
    check_outputs("step");
    model_edge(c, m, r);
    prev_c = c;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send_str(input string s, input bit r);
    for (int i = 0; i < s.len(); i++) step(s[i], gen_match(), r);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    char = "x";
    id_match = 1'b0;
    tok.tok_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    chk("rst_valid", 32'(tok.tok_valid), 32'd0);
    chk("rst_len", 32'(tok.tok_len), 32'd0);
    chk("rst_first", 32'(tok.tok_first), 32'd0);
    chk("rst_count", 32'(id_count), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
  endtask

  function automatic logic [7:0] rand_char();
    int k;
    k = $urandom_range(0, 99);
    if (k < 40) begin
      if ($urandom_range(0, 1) == 1) return 8'(65 + $urandom_range(0, 25));
      return 8'(97 + $urandom_range(0, 25));
    end else if (k < 65) begin
      return 8'(48 + $urandom_range(0, 9));
    end
    case ($urandom_range(0, 3))
      0: return " ";
      1: return ";";
      2: return ",";
      default: return 8'($urandom_range(123, 255));
    endcase
  endfunction

  initial begin
    model_reset();
    rst_n = 1'b0;
    char = " ";
    id_match = 1'b0;
    tok.tok_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    do_reset();

    // Basic token, popped immediately
    send_str("a1 ", 1'b1);
    chk("a1_valid", 32'(tok.tok_valid), 32'd1);
    chk("a1_len", 32'(tok.tok_len), 32'd2);
`ifdef TOKEN_FIRST_CHAR_EN
    chk("a1_first", 32'(tok.tok_first), 32'("a"));
`endif
    chk("a1_count", 32'(id_count), 32'd1);
    step(" ", 1'b0, 1'b1);
    chk("a1_gone", 32'(tok.tok_valid), 32'd0);

    // Leading digits are not part of the run
    do_reset();
    send_str("12ab3;", 1'b0);
    chk("ab3_len", 32'(tok.tok_len), 32'd3);
`ifdef TOKEN_FIRST_CHAR_EN
    chk("ab3_first", 32'(tok.tok_first), 32'("a"));
`endif
    chk("ab3_count", 32'(id_count), 32'd1);

    // Runs not ending in a digit give nothing
    do_reset();
    send_str("abc 9x   ", 1'b1);
    chk("noid_valid", 32'(tok.tok_valid), 32'd0);
    chk("noid_count", 32'(id_count), 32'd0);

    // Overflow with consumer stalled, then drain in order
    do_reset();
    send_str("a1 b2 c3 d4 e5 ", 1'b0);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_drop", 32'(drop_cnt), 32'd1);
    chk("ovf_count", 32'(id_count), 32'd5);
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", 32'(tok.tok_valid), 32'd1);
      chk("drain_len", 32'(tok.tok_len), 32'd2);
      step(" ", 1'b0, 1'b1);
    end
    chk("drain_empty", 32'(tok.tok_valid), 32'd0);
    chk("ovf_sticky", 32'(overflow), 32'd1);

    // Full FIFO: push and pop in the same cycle
    do_reset();
    send_str("a1 b2 c3 d4 e5", 1'b0);
    step(" ", gen_match(), 1'b1);
    chk("fpp_ovf", 32'(overflow), 32'd0);
    chk("fpp_drop", 32'(drop_cnt), 32'd0);
    chk("fpp_count", 32'(id_count), 32'd5);
    for (int i = 0; i < 5; i++) step(" ", 1'b0, 1'b1);
    chk("fpp_empty", 32'(tok.tok_valid), 32'd0);

    // Length saturation
    do_reset();
    for (int i = 0; i < 70; i++) step("q", 1'b0, 1'b0);
    send_str("1 ", 1'b0);
    chk("sat_len", 32'(tok.tok_len), 32'(LEN_MAX));
    step(" ", 1'b0, 1'b1);

    // Reset mid-run discards the partial run
    do_reset();
    send_str("abc1", 1'b0);
    do_reset();
    step(" ", 1'b1, 1'b1);
    chk("midrst_valid", 32'(tok.tok_valid), 32'd0);
    chk("midrst_count", 32'(id_count), 32'd0);

    // Random traffic against the model: stalled phase then mixed ready
    do_reset();
    for (int i = 0; i < 800; i++) begin
      logic [7:0] c;
      bit m;
      bit r;
      c = rand_char();
      m = gen_match();
      if ($urandom_range(0, 9) == 0) m = ~m;
      if (i < 300) r = ($urandom_range(0, 3) == 0);
      else r = ($urandom_range(0, 1) == 1);
      step(c, m, r);
    end
    check_outputs("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
